// File: rtl/p09_spi_level_tx.sv
`default_nettype none
// ============================================================================
//  Module   : p09_spi_level_tx
//  Purpose  : SPI mode-0 frame transmitter. Each accepted request becomes one
//             chip-select-framed burst of 16-bit MSB-first words: a command
//             word {14'b0, cmd_type}, followed by either ctrl_word (CONTROL)
//             or line_count 13-bit lines fetched through a one-deep prefetch
//             (DATA). TERMINATE sends the command word only.
//  Ports    : clk, nRst (async, active-low)
//             cmd_valid/cmd_ready handshake; cmd_type, line_count, ctrl_word
//             line_req/line_idx fetch strobe, line_data returned 1 cycle later
//             spi_cs_n, spi_sck, spi_mosi SPI master outputs
//             busy (acceptance .. done inclusive), done (1-cycle end pulse)
//  Revision : 1.0  initial release
// ============================================================================
module p09_spi_level_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [4:0]  line_count,
    input  logic [15:0] ctrl_word,
    output logic        line_req,
    output logic [4:0]  line_idx,
    input  logic [12:0] line_data,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] shreg;
    logic [3:0]  bit_cnt;
    logic [7:0]  div_cnt;
    logic        sck_q;
    logic        cs_n_q;
    logic        done_q;
    logic        req_q;
    logic        req_d;
    logic [4:0]  idx_q;
    logic [12:0] prefetch;
    logic [5:0]  words_left;   // words still to load after the current one
    logic [4:0]  req_left;     // line fetches still to issue
    logic        is_ctrl;
    logic [15:0] ctrl_q;

    logic        accept;
    logic        phase_end;
    logic        word_end;
    logic [15:0] next_word;

    assign cmd_ready = nRst && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign phase_end = (div_cnt == DIV_LAST);
    assign word_end  = (state == SHIFT) && sck_q && phase_end && (bit_cnt == 4'd15);
    assign next_word = is_ctrl ? ctrl_q : {3'b000, prefetch};

    assign spi_cs_n  = cs_n_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = shreg[15];
    assign line_req  = req_q;
    assign line_idx  = idx_q;
    assign done      = done_q;
    // The done cycle is still part of TAIL, so a new request can never be
    // accepted while done is high and busy covers the done pulse.
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (word_end && (words_left == 6'd0)) state_next = TAIL;
            TAIL:    if (done_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            shreg      <= 16'h0000;
            bit_cnt    <= 4'd0;
            div_cnt    <= 8'd0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
            req_q      <= 1'b0;
            req_d      <= 1'b0;
            idx_q      <= 5'd0;
            prefetch   <= 13'h0000;
            words_left <= 6'd0;
            req_left   <= 5'd0;
            is_ctrl    <= 1'b0;
            ctrl_q     <= 16'h0000;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            req_d  <= req_q;
            // The fetched line arrives exactly one cycle after the strobe.
            if (req_d) begin
                prefetch <= line_data;
            end

            case (state)
                IDLE: begin
                    div_cnt <= 8'd0;
                    bit_cnt <= 4'd0;
                    sck_q   <= 1'b0;
                    if (accept) begin
                        shreg   <= {14'b0, cmd_type};
                        cs_n_q  <= 1'b0;
                        is_ctrl <= (cmd_type == 2'd2);
                        ctrl_q  <= ctrl_word;
                        case (cmd_type)
                            2'd1:    words_left <= {1'b0, line_count};
                            2'd2:    words_left <= 6'd1;
                            default: words_left <= 6'd0;
                        endcase
                        // Word 0 is loaded now; prefetch line 0 if it follows.
                        if ((cmd_type == 2'd1) && (line_count != 5'd0)) begin
                            req_q    <= 1'b1;
                            idx_q    <= 5'd0;
                            req_left <= line_count - 5'd1;
                        end else begin
                            req_left <= 5'd0;
                        end
                    end
                end

                SHIFT: begin
                    if (phase_end) begin
                        div_cnt <= 8'd0;
                        sck_q   <= ~sck_q;
                        // MOSI only moves when a high phase ends, i.e. at the
                        // start of the following low phase.
                        if (sck_q) begin
                            if (bit_cnt == 4'd15) begin
                                bit_cnt <= 4'd0;
                                if (words_left == 6'd0) begin
                                    shreg <= 16'h0000;
                                end else begin
                                    shreg      <= next_word;
                                    words_left <= words_left - 6'd1;
                                    if (req_left != 5'd0) begin
                                        req_q    <= 1'b1;
                                        idx_q    <= idx_q + 5'd1;
                                        req_left <= req_left - 5'd1;
                                    end
                                end
                            end else begin
                                shreg   <= {shreg[14:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                TAIL: begin
                    if (!done_q) begin
                        if (phase_end) begin
                            div_cnt <= 8'd0;
                            cs_n_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    cs_n_q <= 1'b1;
                    sck_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_p09_spi_level_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_p09_spi_level_tx
//  Purpose  : Directed bench for p09_spi_level_tx. Instance 0 uses CLK_DIV=2,
//             instance 1 uses CLK_DIV=1. A line responder returns table data
//             exactly one cycle after each line_req (a fixed filler value on
//             every other cycle); a monitor decodes MOSI words on rising SCK.
//  Revision : 1.0  initial release
// ============================================================================
module tb_p09_spi_level_tx;

    logic        clk;
    logic        nRst       [2];
    logic        cmd_valid  [2];
    logic        cmd_ready  [2];
    logic [1:0]  cmd_type   [2];
    logic [4:0]  line_count [2];
    logic [15:0] ctrl_word  [2];
    logic        line_req   [2];
    logic [4:0]  line_idx   [2];
    logic [12:0] line_data  [2];
    logic        spi_cs_n   [2];
    logic        spi_sck    [2];
    logic        spi_mosi   [2];
    logic        busy       [2];
    logic        done       [2];

    p09_spi_level_tx #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .nRst(nRst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_type(cmd_type[0]), .line_count(line_count[0]), .ctrl_word(ctrl_word[0]),
        .line_req(line_req[0]), .line_idx(line_idx[0]), .line_data(line_data[0]),
        .spi_cs_n(spi_cs_n[0]), .spi_sck(spi_sck[0]), .spi_mosi(spi_mosi[0]),
        .busy(busy[0]), .done(done[0])
    );

    p09_spi_level_tx #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .nRst(nRst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_type(cmd_type[1]), .line_count(line_count[1]), .ctrl_word(ctrl_word[1]),
        .line_req(line_req[1]), .line_idx(line_idx[1]), .line_data(line_data[1]),
        .spi_cs_n(spi_cs_n[1]), .spi_sck(spi_sck[1]), .spi_mosi(spi_mosi[1]),
        .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- line responder ----------------
    logic [12:0] mem [2][32];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            line_data[d] <= line_req[d] ? mem[d][line_idx[d]] : 13'h1555;
        end
    end

    // ---------------- monitor ----------------
    logic [15:0] wbuf [2][512];
    logic [4:0]  ibuf [2][64];
    int          wn [2], rn [2], cs_low [2], done_cnt [2];
    int          mviol [2], bviol [2], gviol [2], bc [2];
    logic [15:0] sh [2];
    logic        psck [2], pmosi [2], pcs [2], pdone [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            wn[d] = 0; rn[d] = 0; cs_low[d] = 0; done_cnt[d] = 0;
            mviol[d] = 0; bviol[d] = 0; gviol[d] = 0; bc[d] = 0; sh[d] = 16'h0;
            psck[d] = 1'b0; pmosi[d] = 1'b0; pcs[d] = 1'b1; pdone[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!nRst[d]) begin
                bc[d] = 0;
            end else begin
                if (!spi_cs_n[d]) cs_low[d]++;
                if (spi_sck[d] && !psck[d] && !spi_cs_n[d]) begin
                    sh[d] = {sh[d][14:0], spi_mosi[d]};
                    bc[d]++;
                    if (bc[d] == 16) begin
                        wbuf[d][wn[d] % 512] = sh[d];
                        wn[d]++;
                        bc[d] = 0;
                    end
                end
                // MOSI may only move where SCK has just fallen inside a frame.
                if (!spi_cs_n[d] && !pcs[d] && (spi_mosi[d] !== pmosi[d]) && !(psck[d] && !spi_sck[d]))
                    mviol[d]++;
                if (busy[d] !== !cmd_ready[d]) bviol[d]++;
                if (pdone[d] && busy[d]) gviol[d]++;
                if (done[d]) done_cnt[d]++;
                if (line_req[d]) begin
                    ibuf[d][rn[d] % 64] = line_idx[d];
                    rn[d]++;
                end
            end
            psck[d]  = spi_sck[d];
            pmosi[d] = spi_mosi[d];
            pcs[d]   = spi_cs_n[d];
            pdone[d] = done[d];
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [1:0] t, input logic [4:0] lc, input logic [15:0] cw);
        int b;
        b = 0;
        cmd_type[d] = t; line_count[d] = lc; ctrl_word[d] = cw; cmd_valid[d] = 1'b1;
        while (!cmd_ready[d] && b < 2000) begin @(negedge clk); b++; end
        @(negedge clk);
        // Scramble request fields after acceptance; the frame must ignore them.
        cmd_valid[d] = 1'b0; cmd_type[d] = ~t; line_count[d] = ~lc; ctrl_word[d] = ~cw;
    endtask

    task automatic wait_done(input int d, input string tag);
        int b;
        b = 0;
        while (!done[d] && b < 5000) begin @(negedge clk); b++; end
        chk(tag, 32'(b < 5000), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    int w0, c0, d0, r0;

    task automatic snap(input int d);
        w0 = wn[d]; c0 = cs_low[d]; d0 = done_cnt[d]; r0 = rn[d];
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            nRst[d] = 1'b1; cmd_valid[d] = 1'b0; cmd_type[d] = 2'd0;
            line_count[d] = 5'd0; ctrl_word[d] = 16'h0;
        end
        mem[0][0] = 13'h1FFF; mem[0][1] = 13'h0000; mem[0][2] = 13'h0AAA;
        for (int i = 3; i < 32; i++) mem[0][i] = 13'h0123;
        for (int i = 0; i < 32; i++) mem[1][i] = 13'(i * 37 + 5);
        #1;
        nRst[0] = 1'b0; nRst[1] = 1'b0;
        #2;
        chk("rst_cs_n",  32'(spi_cs_n[0]),  32'd1);
        chk("rst_sck",   32'(spi_sck[0]),   32'd0);
        chk("rst_mosi",  32'(spi_mosi[0]),  32'd0);
        chk("rst_req",   32'(line_req[0]),  32'd0);
        chk("rst_idx",   32'(line_idx[0]),  32'd0);
        chk("rst_busy",  32'(busy[0]),      32'd0);
        chk("rst_done",  32'(done[0]),      32'd0);
        chk("rst_ready", 32'(cmd_ready[0]), 32'd0);
        repeat (3) @(negedge clk);
        nRst[0] = 1'b1; nRst[1] = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready[0]), 32'd1);

        // CONTROL, ctrl_word = 0001
        snap(0);
        send(0, 2'd2, 5'd0, 16'h0001);
        wait_done(0, "ctrl_done_to");
        chk("ctrl_words",  32'(wn[0] - w0), 32'd2);
        chk("ctrl_w0",     32'(wbuf[0][w0 % 512]), 32'h0002);
        chk("ctrl_w1",     32'(wbuf[0][(w0 + 1) % 512]), 32'h0001);
        chk("ctrl_cs_low", 32'(cs_low[0] - c0), 32'd130);
        chk("ctrl_done",   32'(done_cnt[0] - d0), 32'd1);
        chk("ctrl_noreq",  32'(rn[0] - r0), 32'd0);

        // DATA, 3 lines
        snap(0);
        send(0, 2'd1, 5'd3, 16'hFFFF);
        wait_done(0, "data3_done_to");
        chk("data3_words", 32'(wn[0] - w0), 32'd4);
        chk("data3_w0", 32'(wbuf[0][w0 % 512]), 32'h0001);
        chk("data3_w1", 32'(wbuf[0][(w0 + 1) % 512]), 32'h1FFF);
        chk("data3_w2", 32'(wbuf[0][(w0 + 2) % 512]), 32'h0000);
        chk("data3_w3", 32'(wbuf[0][(w0 + 3) % 512]), 32'h0AAA);
        chk("data3_nreq", 32'(rn[0] - r0), 32'd3);
        chk("data3_idx0", 32'(ibuf[0][r0 % 64]), 32'd0);
        chk("data3_idx1", 32'(ibuf[0][(r0 + 1) % 64]), 32'd1);
        chk("data3_idx2", 32'(ibuf[0][(r0 + 2) % 64]), 32'd2);
        chk("data3_cs_low", 32'(cs_low[0] - c0), 32'd258);

        // DATA, 0 lines
        snap(0);
        send(0, 2'd1, 5'd0, 16'h0);
        wait_done(0, "data0_done_to");
        chk("data0_words",  32'(wn[0] - w0), 32'd1);
        chk("data0_w0",     32'(wbuf[0][w0 % 512]), 32'h0001);
        chk("data0_cs_low", 32'(cs_low[0] - c0), 32'd66);
        chk("data0_noreq",  32'(rn[0] - r0), 32'd0);

        // TERMINATE, type 3 and type 0
        snap(0);
        send(0, 2'd3, 5'd7, 16'h5555);
        wait_done(0, "term3_done_to");
        chk("term3_words",  32'(wn[0] - w0), 32'd1);
        chk("term3_w0",     32'(wbuf[0][w0 % 512]), 32'h0003);
        chk("term3_cs_low", 32'(cs_low[0] - c0), 32'd66);
        chk("term3_noreq",  32'(rn[0] - r0), 32'd0);
        snap(0);
        send(0, 2'd0, 5'd7, 16'h5555);
        wait_done(0, "term0_done_to");
        chk("term0_w0",     32'(wbuf[0][w0 % 512]), 32'h0000);
        chk("term0_cs_low", 32'(cs_low[0] - c0), 32'd66);

        // cmd_valid held high across two frames
        snap(0);
        cmd_type[0] = 2'd2; ctrl_word[0] = 16'hABCD; cmd_valid[0] = 1'b1;
        begin
            int b;
            int seen;
            b = 0; seen = 0;
            while (seen < 2 && b < 5000) begin
                @(negedge clk); b++;
                if (done[0]) seen++;
            end
            cmd_valid[0] = 1'b0;
            chk("held_to", 32'(b < 5000), 32'd1);
        end
        repeat (3) @(negedge clk);
        chk("held_done",  32'(done_cnt[0] - d0), 32'd2);
        chk("held_w0",    32'(wbuf[0][w0 % 512]), 32'h0002);
        chk("held_w1",    32'(wbuf[0][(w0 + 1) % 512]), 32'hABCD);
        chk("held_w2",    32'(wbuf[0][(w0 + 2) % 512]), 32'h0002);
        chk("held_w3",    32'(wbuf[0][(w0 + 3) % 512]), 32'hABCD);
        chk("held_gap",   32'(gviol[0]), 32'd0);
        chk("busy_ready", 32'(bviol[0]), 32'd0);
        chk("mosi_stab0", 32'(mviol[0]), 32'd0);

        // CLK_DIV = 1, DATA with 31 lines
        snap(1);
        send(1, 2'd1, 5'd31, 16'h0);
        wait_done(1, "data31_done_to");
        chk("data31_words",  32'(wn[1] - w0), 32'd32);
        chk("data31_w0",     32'(wbuf[1][w0 % 512]), 32'h0001);
        for (int i = 0; i < 31; i++) begin
            chk($sformatf("data31_w%0d", i + 1), 32'(wbuf[1][(w0 + 1 + i) % 512]), {19'b0, mem[1][i]});
            chk($sformatf("data31_idx%0d", i), 32'(ibuf[1][(r0 + i) % 64]), 32'(i));
        end
        chk("data31_nreq",   32'(rn[1] - r0), 32'd31);
        chk("data31_cs_low", 32'(cs_low[1] - c0), 32'd1025);
        chk("mosi_stab1",    32'(mviol[1]), 32'd0);

        // Reset in the middle of a DATA word, then a CONTROL frame
        snap(1);
        send(1, 2'd1, 5'd5, 16'h0);
        repeat (40) @(negedge clk);
        #2;
        nRst[1] = 1'b0;
        #1;
        chk("abort_cs_n",  32'(spi_cs_n[1]),  32'd1);
        chk("abort_sck",   32'(spi_sck[1]),   32'd0);
        chk("abort_busy",  32'(busy[1]),      32'd0);
        chk("abort_ready", 32'(cmd_ready[1]), 32'd0);
        chk("abort_req",   32'(line_req[1]),  32'd0);
        repeat (3) @(negedge clk);
        nRst[1] = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", 32'(cmd_ready[1]), 32'd1);
        chk("abort_no_done",     32'(done_cnt[1] - d0), 32'd0);
        snap(1);
        send(1, 2'd2, 5'd0, 16'h1234);
        wait_done(1, "post_done_to");
        chk("post_words",  32'(wn[1] - w0), 32'd2);
        chk("post_w0",     32'(wbuf[1][w0 % 512]), 32'h0002);
        chk("post_w1",     32'(wbuf[1][(w0 + 1) % 512]), 32'h1234);
        chk("post_cs_low", 32'(cs_low[1] - c0), 32'd65);
        chk("post_done",   32'(done_cnt[1] - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
